byte_store_master: RTL and testbench
====================================

Name: byte_store_master

Overview:
- Initiator for the byte-wide store interface. Accepts one word-level read or write request from a host through a valid/ready handshake.
- Splits each request into WORD_BYTES sequential byte accesses on the store side, using the store's read_enable, write_enable and data_in inputs. Collects the store's data_out with its 1-cycle read latency.
- Sits between the host datapath and byte-granular storage. Returns one response per request.

Parameters:
- WORD_BYTES, 4, bytes per host word (>=2).
- ADDR_W, 8, store byte-address width.

Ports:
- clk  in  1  clock
- rst  in  1  synchronous reset, active-high
- req_valid  in  1  host request valid
- req_ready  out  1  master can accept a request
- req_write  in  1  1=write, 0=read
- req_addr  in  ADDR_W  base byte address
- req_wdata  in  8*WORD_BYTES  write word, little-endian
- resp_valid  out  1  response valid, held until accepted
- resp_ready  in  1  host accepts response
- resp_rdata  out  8*WORD_BYTES  read word; 0 for writes
- resp_error  out  1  store did not assert output_enable during a read issue
- st_addr  out  ADDR_W  store byte address
- st_write_enable  out  1  store write strobe
- st_read_enable  out  1  store read strobe
- st_data_in  out  8  byte to store
- st_data_out  in  8  store read data, valid the cycle after st_read_enable
- st_output_enable  in  1  store read acknowledge, same cycle as st_read_enable

Behaviour:
- Reset sets:
  - state IDLE, req_ready=1, resp_valid=0, resp_rdata=0, resp_error=0
  - st_* strobes=0, st_addr=0, st_data_in=0
  - byte counter=0, rd_pending=0
- All outputs are decoded from flops only. There is no combinational path from any input to any output.
- States and transitions:
  - IDLE: req_ready=1. On req_valid&&req_ready, latch addr, wdata and write, clear the counter, clear the error flag, and go to WRITE or READ. req_ready=0 in every other state.
  - WRITE: each cycle, drive st_write_enable=1, st_addr=base+i, st_data_in=wdata[8i+7:8i], for i=0..WORD_BYTES-1. After the last byte, go to RESP.
  - READ: each cycle, drive st_read_enable=1, st_addr=base+i.
    - rd_pending is registered from (st_read_enable, captured index i).
    - In the following cycle, st_data_out is written into rdata byte i.
    - If st_output_enable=0 in an issue cycle, set the sticky resp_error.
    - After the last issue, go to DRAIN.
  - DRAIN: capture the final byte, then go to RESP.
  - RESP: resp_valid=1 with rdata and error stable. On resp_ready, go to IDLE.
- A write and a read strobe are never asserted in the same cycle.
- Latency (request accepted at edge 0):
  - Write: bytes driven in cycles 1..W; resp_valid from cycle W+1.
  - Read: issues in cycles 1..W, captures at edges 2..W+1, DRAIN in cycle W+1, resp_valid from cycle W+2.
- Address arithmetic: base+i is computed modulo 2^ADDR_W. A request at 0xFE with W=4 wraps to 0xFE, 0xFF, 0x00, 0x01.
- Back-to-back: a new request can be accepted in the cycle after resp_valid&&resp_ready, once IDLE is re-entered.
- req_valid outside IDLE is ignored; the host must hold it.
- Reset mid-operation aborts immediately: strobes drop the same edge, the pending capture is discarded, and no response is issued.
- resp_ready held high before RESP: the response lasts exactly 1 cycle.

Decomposition:
- Shared package holds:
  - state enum {IDLE, WRITE, READ, DRAIN, RESP}
  - BYTE_W=8 constant
  - a function for the little-endian byte-lane slice
- One sub-module, byte_lane_assembler: shifts or inserts captured bytes into the response word under a lane index and clear. Everything else stays inline.

Test Plan:
- Write then read (W=4, store model at base 0x10): write 0xA1B2C3D4, then read 0x10 -> store holds D4,C3,B2,A1 at 0x10..0x13. Read resp_rdata=0xA1B2C3D4, resp_error=0, resp_valid at cycle 6 after acceptance.
- Address wrap: write 0x11223344 at 0xFE -> bytes 44,33,22,11 land at 0xFE, 0xFF, 0x00, 0x01. Readback matches.
- Response backpressure: hold resp_ready=0 for 5 cycles -> resp_valid and resp_rdata stay stable, req_ready=0, and a second req_valid is not accepted until one cycle after the handshake.
- Missing acknowledge: store model drops output_enable on byte 2 of a read -> resp_error=1. The other lanes still hold the store's data_out.
- Reset mid-read: assert rst in the 2nd issue cycle -> next cycle all strobes=0, req_ready=1, resp_valid=0. A following request completes normally.
- Back-to-back writes with resp_ready tied to 1 -> exactly one 1-cycle resp_valid per request, and no overlapping store strobes.

Source files
------------

// File: rtl/byte_store_master_pkg.sv
// Shared types and helpers for the byte-wide store master.
package byte_store_master_pkg;

   localparam int BYTE_W     = 8;
   // Widest host word the lane helper accepts (8 bytes).
   localparam int MAX_WORD_W = 64;

   typedef logic [2:0] state_t;

   localparam state_t IDLE  = 3'd0;
   localparam state_t WRITE = 3'd1;
   localparam state_t READ  = 3'd2;
   localparam state_t DRAIN = 3'd3;
   localparam state_t RESP  = 3'd4;

   // Little-endian byte lane idx of a (zero-extended) word.
   function automatic logic [BYTE_W-1:0] lane_byte(input logic [MAX_WORD_W-1:0] w,
                                                   input int unsigned idx);
      return w[idx*BYTE_W +: BYTE_W];
   endfunction

endpackage

// File: rtl/byte_store_master_lane_asm.sv
// Builds the response word one captured byte at a time.
module byte_lane_assembler
   import byte_store_master_pkg::*;
#(
   parameter int WORD_BYTES = 4,
   parameter int IDX_W      = $clog2(WORD_BYTES)
) (
   input  logic                         clk,
   input  logic                         rst,
   input  logic                         clr,
   input  logic                         cap_en,
   input  logic [IDX_W-1:0]             lane_idx,
   input  logic [BYTE_W-1:0]            cap_byte,
   output logic [BYTE_W*WORD_BYTES-1:0] word
);

   // Clear on a new request, otherwise drop the captured byte into its lane.
   always_ff @(posedge clk) begin
      if (rst || clr)
         word <= '0;
      else if (cap_en)
         word[lane_idx*BYTE_W +: BYTE_W] <= cap_byte;
   end

endmodule

// File: rtl/byte_store_master.sv
// Word-level host request -> sequence of byte accesses on the store port.
// All outputs are registered; the store's read data is taken one cycle
// after each read strobe.
module byte_store_master
   import byte_store_master_pkg::*;
#(
   parameter int WORD_BYTES = 4,
   parameter int ADDR_W     = 8
) (
   input  logic                         clk,
   input  logic                         rst,
   input  logic                         req_valid,
   output logic                         req_ready,
   input  logic                         req_write,
   input  logic [ADDR_W-1:0]            req_addr,
   input  logic [BYTE_W*WORD_BYTES-1:0] req_wdata,
   output logic                         resp_valid,
   input  logic                         resp_ready,
   output logic [BYTE_W*WORD_BYTES-1:0] resp_rdata,
   output logic                         resp_error,
   output logic [ADDR_W-1:0]            st_addr,
   output logic                         st_write_enable,
   output logic                         st_read_enable,
   output logic [BYTE_W-1:0]            st_data_in,
   input  logic [BYTE_W-1:0]            st_data_out,
   input  logic                         st_output_enable
);

   localparam int WORD_W = BYTE_W*WORD_BYTES;
   localparam int CNT_W  = $clog2(WORD_BYTES);
   localparam logic [CNT_W-1:0] LAST = CNT_W'(WORD_BYTES-1);

   state_t            state;
   logic [CNT_W-1:0]  cnt;
   logic [CNT_W-1:0]  nxt;
   logic [ADDR_W-1:0] addr_q;
   logic [WORD_W-1:0] wdata_q;
   logic              rd_pending;
   logic [CNT_W-1:0]  rd_idx;
   logic              accept;

   // Next byte index and the request handshake.
   always_comb begin
      nxt    = cnt + 1'b1;
      accept = (state == IDLE) && req_valid && req_ready;
   end

   // Control FSM; every output is set one edge ahead of the cycle it is seen.
   always_ff @(posedge clk) begin
      if (rst) begin
         state           <= IDLE;
         req_ready       <= 1'b1;
         resp_valid      <= 1'b0;
         resp_error      <= 1'b0;
         st_addr         <= '0;
         st_write_enable <= 1'b0;
         st_read_enable  <= 1'b0;
         st_data_in      <= '0;
         cnt             <= '0;
         rd_pending      <= 1'b0;
         rd_idx          <= '0;
         addr_q          <= '0;
         wdata_q         <= '0;
      end else begin
         // Read data returns one cycle after the strobe; remember its lane.
         rd_pending <= st_read_enable;
         rd_idx     <= cnt;
         if (st_read_enable && !st_output_enable)
            resp_error <= 1'b1;
         case (state)
            IDLE: begin
               if (accept) begin
                  addr_q     <= req_addr;
                  wdata_q    <= req_wdata;
                  cnt        <= '0;
                  resp_error <= 1'b0;
                  req_ready  <= 1'b0;
                  st_addr    <= req_addr;
                  if (req_write) begin
                     state           <= WRITE;
                     st_write_enable <= 1'b1;
                     st_data_in      <= req_wdata[BYTE_W-1:0];
                  end else begin
                     state          <= READ;
                     st_read_enable <= 1'b1;
                  end
               end
            end
            WRITE: begin
               if (cnt == LAST) begin
                  state           <= RESP;
                  st_write_enable <= 1'b0;
                  st_data_in      <= '0;
                  resp_valid      <= 1'b1;
               end else begin
                  cnt        <= nxt;
                  st_addr    <= addr_q + ADDR_W'(nxt);
                  st_data_in <= lane_byte(MAX_WORD_W'(wdata_q), 32'(nxt));
               end
            end
            READ: begin
               if (cnt == LAST) begin
                  state          <= DRAIN;
                  st_read_enable <= 1'b0;
               end else begin
                  cnt     <= nxt;
                  st_addr <= addr_q + ADDR_W'(nxt);
               end
            end
            DRAIN: begin
               state      <= RESP;
               resp_valid <= 1'b1;
            end
            RESP: begin
               if (resp_ready) begin
                  state      <= IDLE;
                  resp_valid <= 1'b0;
                  req_ready  <= 1'b1;
               end
            end
            default: begin
               state      <= IDLE;
               req_ready  <= 1'b1;
               resp_valid <= 1'b0;
            end
         endcase
      end
   end

   byte_lane_assembler #(
      .WORD_BYTES (WORD_BYTES),
      .IDX_W      (CNT_W)
   ) u_asm (
      .clk      (clk),
      .rst      (rst),
      .clr      (accept),
      .cap_en   (rd_pending),
      .lane_idx (rd_idx),
      .cap_byte (st_data_out),
      .word     (resp_rdata)
   );

endmodule

// File: tb/tb_byte_store_master.sv
// Directed bench for byte_store_master with a behavioural byte store.
module tb_byte_store_master;

   localparam int W = 4;

   logic        clk = 1'b0;
   logic        rst;
   logic        req_valid, req_ready, req_write;
   logic [7:0]  req_addr;
   logic [31:0] req_wdata;
   logic        resp_valid, resp_ready, resp_error;
   logic [31:0] resp_rdata;
   logic [7:0]  st_addr, st_data_in, st_data_out;
   logic        st_write_enable, st_read_enable, st_output_enable;

   logic [7:0]  mem [256];
   logic        drop_en;
   logic [7:0]  drop_addr;

   int n_cmp = 0, n_err = 0;
   int rv_cycles = 0, rv_rises = 0, overlap = 0;
   logic rv_prev = 1'b0;

   typedef struct {
      logic        wr;
      logic [7:0]  addr;
      logic [31:0] wdata;
      logic [31:0] exp;
      logic [31:0] mask;
      logic        err;
      int          lat;
   } vec_t;

   vec_t vecs [8];

   byte_store_master #(.WORD_BYTES(W), .ADDR_W(8)) dut (
      .clk(clk), .rst(rst),
      .req_valid(req_valid), .req_ready(req_ready), .req_write(req_write),
      .req_addr(req_addr), .req_wdata(req_wdata),
      .resp_valid(resp_valid), .resp_ready(resp_ready),
      .resp_rdata(resp_rdata), .resp_error(resp_error),
      .st_addr(st_addr), .st_write_enable(st_write_enable),
      .st_read_enable(st_read_enable), .st_data_in(st_data_in),
      .st_data_out(st_data_out), .st_output_enable(st_output_enable)
   );

   always #5 clk = ~clk;

   // Byte store: acknowledge in the strobe cycle, data one cycle later.
   assign st_output_enable = st_read_enable && !(drop_en && st_addr == drop_addr);

   always @(posedge clk) begin
      if (st_write_enable) mem[st_addr] <= st_data_in;
      if (st_read_enable)  st_data_out <= st_output_enable ? mem[st_addr] : 8'h00;
   end

   // Response pulse and strobe-overlap monitor.
   always @(negedge clk) begin
      rv_prev <= resp_valid;
      if (resp_valid) rv_cycles <= rv_cycles + 1;
      if (resp_valid && !rv_prev) rv_rises <= rv_rises + 1;
      if (st_write_enable && st_read_enable) overlap <= overlap + 1;
   end

   task automatic tick;
      @(posedge clk);
      #1;
   endtask

   task automatic chk(input string nm, input logic [63:0] got, input logic [63:0] exp);
      n_cmp++;
      if (got !== exp) begin
         n_err++;
         $display("FAIL %s: got %0h want %0h", nm, got, exp);
      end
   endtask

   task automatic chk_mem(input string nm, input logic [7:0] a, input logic [31:0] exp);
      logic [7:0] a1, a2, a3;
      a1 = a + 8'd1; a2 = a + 8'd2; a3 = a + 8'd3;
      chk(nm, {mem[a3], mem[a2], mem[a1], mem[a]}, exp);
   endtask

   task automatic wait_resp(output int lat);
      lat = 1;
      while (!resp_valid && lat < 50) begin
         tick;
         lat++;
      end
   endtask

   task automatic do_req(input vec_t v, input string nm);
      int lat;
      chk({nm, " req_ready"}, req_ready, 1);
      req_valid = 1'b1; req_write = v.wr; req_addr = v.addr; req_wdata = v.wdata;
      tick;
      req_valid = 1'b0;
      wait_resp(lat);
      chk({nm, " latency"}, lat, v.lat);
      chk({nm, " rdata"}, resp_rdata & v.mask, v.exp & v.mask);
      chk({nm, " error"}, resp_error, v.err);
      if (v.wr) chk_mem({nm, " store"}, v.addr, v.wdata);
      resp_ready = 1'b1;
      tick;
      resp_ready = 1'b0;
      chk({nm, " resp_drop"}, resp_valid, 0);
      chk({nm, " idle_ready"}, req_ready, 1);
   endtask

   initial begin
      #2_000_000;
      $display("FAIL watchdog: simulation did not finish");
      $fatal(1);
   end

   initial begin
      int lat, r0, c0;
      logic [31:0] bb_data [3];
      vec_t v;

      for (int i = 0; i < 256; i++) mem[i] = 8'h00;
      drop_en = 1'b0; drop_addr = 8'h00;
      rst = 1'b1; req_valid = 1'b0; req_write = 1'b0; req_addr = '0; req_wdata = '0;
      resp_ready = 1'b0;

      vecs[0] = '{1'b1, 8'h10, 32'hA1B2C3D4, 32'h0,        32'hFFFFFFFF, 1'b0, W+1};
      vecs[1] = '{1'b0, 8'h10, 32'h0,        32'hA1B2C3D4, 32'hFFFFFFFF, 1'b0, W+2};
      vecs[2] = '{1'b1, 8'hFE, 32'h11223344, 32'h0,        32'hFFFFFFFF, 1'b0, W+1};
      vecs[3] = '{1'b0, 8'hFE, 32'h0,        32'h11223344, 32'hFFFFFFFF, 1'b0, W+2};
      vecs[4] = '{1'b1, 8'h40, 32'h000000FF, 32'h0,        32'hFFFFFFFF, 1'b0, W+1};
      vecs[5] = '{1'b0, 8'h40, 32'h0,        32'h000000FF, 32'hFFFFFFFF, 1'b0, W+2};
      vecs[6] = '{1'b0, 8'h11, 32'h0,        32'h00A1B2C3, 32'hFFFFFFFF, 1'b0, W+2};
      vecs[7] = '{1'b0, 8'h00, 32'h0,        32'h00001122, 32'hFFFFFFFF, 1'b0, W+2};

      // Reset state
      tick; tick;
      chk("rst req_ready",  req_ready, 1);
      chk("rst resp_valid", resp_valid, 0);
      chk("rst resp_rdata", resp_rdata, 0);
      chk("rst resp_error", resp_error, 0);
      chk("rst strobes",    {st_write_enable, st_read_enable}, 0);
      chk("rst st_addr",    st_addr, 0);
      chk("rst st_data_in", st_data_in, 0);
      rst = 1'b0;
      tick;

      for (int i = 0; i < 8; i++) do_req(vecs[i], $sformatf("vec%0d", i));
      chk_mem("wrap bytes", 8'hFE, 32'h11223344);

      // Missing acknowledge on byte 2; other lanes still from the store.
      drop_en = 1'b1; drop_addr = 8'h12;
      v = '{1'b0, 8'h10, 32'h0, 32'hA1B2C3D4, 32'hFF00FFFF, 1'b1, W+2};
      do_req(v, "noack");
      drop_en = 1'b0;

      // Response backpressure with a second request waiting.
      req_valid = 1'b1; req_write = 1'b0; req_addr = 8'h10;
      tick;
      req_write = 1'b1; req_addr = 8'h50; req_wdata = 32'hCAFEF00D;
      wait_resp(lat);
      chk("bp latency", lat, W+2);
      for (int k = 0; k < 5; k++) begin
         chk("bp resp_valid", resp_valid, 1);
         chk("bp rdata",      resp_rdata, 32'hA1B2C3D4);
         chk("bp error",      resp_error, 0);
         chk("bp req_ready",  req_ready, 0);
         chk("bp no_write",   st_write_enable, 0);
         tick;
      end
      resp_ready = 1'b1;
      tick;
      resp_ready = 1'b0;
      chk("bp after_hs ready", req_ready, 1);
      chk("bp after_hs idle",  st_write_enable, 0);
      tick;
      req_valid = 1'b0;
      chk("bp 2nd we",   st_write_enable, 1);
      chk("bp 2nd addr", st_addr, 8'h50);
      chk("bp 2nd byte", st_data_in, 8'h0D);
      wait_resp(lat);
      chk("bp 2nd latency", lat, W+1);
      resp_ready = 1'b1;
      tick;
      resp_ready = 1'b0;
      chk_mem("bp 2nd store", 8'h50, 32'hCAFEF00D);

      // Reset in the second read issue cycle.
      r0 = rv_rises;
      req_valid = 1'b1; req_write = 1'b0; req_addr = 8'h10;
      tick;
      req_valid = 1'b0;
      tick;
      chk("mid issue re",   st_read_enable, 1);
      chk("mid issue addr", st_addr, 8'h11);
      rst = 1'b1;
      tick;
      chk("mid strobes",    {st_write_enable, st_read_enable}, 0);
      chk("mid req_ready",  req_ready, 1);
      chk("mid resp_valid", resp_valid, 0);
      rst = 1'b0;
      for (int k = 0; k < 8; k++) tick;
      chk("mid no_resp", rv_rises - r0, 0);
      do_req(vecs[1], "post_rst");

      // Back-to-back writes, resp_ready tied high.
      bb_data[0] = 32'h01020304; bb_data[1] = 32'hDEADBEEF; bb_data[2] = 32'h5A5AA5A5;
      r0 = rv_rises; c0 = rv_cycles;
      resp_ready = 1'b1;
      for (int k = 0; k < 3; k++) begin
         lat = 0;
         while (!req_ready && lat < 50) begin tick; lat++; end
         chk("b2b ready_wait", lat < 50, 1);
         req_valid = 1'b1; req_write = 1'b1;
         req_addr = 8'h60 + 8'(4*k); req_wdata = bb_data[k];
         tick;
         req_valid = 1'b0;
      end
      for (int k = 0; k < 10; k++) tick;
      resp_ready = 1'b0;
      chk("b2b resp_pulses", rv_rises - r0, 3);
      chk("b2b resp_cycles", rv_cycles - c0, 3);
      for (int k = 0; k < 3; k++) chk_mem("b2b store", 8'h60 + 8'(4*k), bb_data[k]);

      chk("no strobe overlap", overlap, 0);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

endmodule
